count_display: RTL

COUNT_DISPLAY -- requirements
Module: count_display

---
 rtl/count_display.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/count_display.sv
// count_display
// Converts an 8-bit binary count to three BCD digits with a sequential
// double-dabble engine, then time-multiplexes the digits onto a single
// seven-segment driver with leading-zero blanking.
//
// Parameters:
//   SCAN_DIV : clock cycles each digit is held during the scan (1..65535)
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-high reset
//   count : 8-bit unsigned value to display
//   bcd   : registered BCD of the last converted value {hundreds, tens, units}
//   busy  : high while a conversion is in progress
//   an    : one-hot digit enable, an[0] units, an[1] tens, an[2] hundreds
//   seg   : active-high segment drive, seg[0]=a ... seg[6]=g

module count_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  count,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

    state_t      state;
    logic [7:0]  shreg;
    logic [7:0]  cap_val;
    logic [7:0]  last_val;
    logic [11:0] acc;
    logic [2:0]  iter;
    logic        flag;
    logic [11:0] acc_adj;
    logic [19:0] dabble;
    logic [15:0] prescale;
    logic [1:0]  digit;
    logic [3:0]  nib;
    logic        blank;

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // One double-dabble step: add-3 correction on every nibble, then shift
    // the combined {accumulator, shift register} left by one bit.
    assign acc_adj = {adj(acc[11:8]), adj(acc[7:4]), adj(acc[3:0])};
    assign dabble  = {acc_adj, shreg} << 1;

    // Conversion FSM. The captured value is kept apart from the shift
    // register because the shift register is consumed by the conversion.
    // The post-reset flag forces one conversion even when count equals the
    // reset value of last_val.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= 8'd0;
            cap_val  <= 8'd0;
            last_val <= 8'd0;
            acc      <= 12'd0;
            iter     <= 3'd0;
            flag     <= 1'b1;
            bcd      <= 12'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((count != last_val) || flag) begin
                        shreg   <= count;
                        cap_val <= count;
                        acc     <= 12'd0;
                        iter    <= 3'd0;
                        flag    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, shreg} <= dabble;
                    iter         <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd      <= acc;
                    last_val <= cap_val;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scan prescaler and digit index; the index advances only when the
    // prescaler wraps, so each digit is held for SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= 16'd0;
            digit    <= 2'd0;
        end else if (prescale == PRE_MAX) begin
            prescale <= 16'd0;
            digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        end else begin
            prescale <= prescale + 16'd1;
        end
    end

    // Digit select and segment decode from the registered bcd only, so the
    // display never shows a partially converted value. Leading zeros in the
    // hundreds and tens positions are blanked; units always show.
    always_comb begin
        an    = 3'b001;
        nib   = bcd[3:0];
        blank = 1'b0;
        case (digit)
            2'd1: begin
                an    = 3'b010;
                nib   = bcd[7:4];
                blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                an    = 3'b100;
                nib   = bcd[11:8];
                blank = (bcd[11:8] == 4'd0);
            end
            default: begin
                an    = 3'b001;
                nib   = bcd[3:0];
                blank = 1'b0;
            end
        endcase
        seg = blank ? 7'h00 : decode(nib);
    end

endmodule
